lbp_img_host: RTL and testbench
===============================

Name: lbp_img_host

Overview:
- Image-side responder for the LBP engine's RGB fetch / gray+LBP write-back interface.
- Holds a preloaded 128x128 RGB image and serves RGB_req reads with combinational data.
- Raises RGB_ready once loading completes, captures every gray_valid/lbp_valid write into result buffers, and latches finish.
- Sits between the system loader or readback logic and the LBP engine.

Parameters:
- ADDR_W, 14, pixel address width (image depth = 2**ADDR_W = 16384).
- PIX_W, 24, RGB word width: R[23:16], G[15:8], B[7:0].
- RES_W, 8, gray/LBP result width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_valid  in  1  image load strobe
- load_addr  in  ADDR_W  load pixel address
- load_data  in  PIX_W  load pixel value
- load_last  in  1  with load_valid: final load word
- RGB_ready  out  1  image available to engine
- RGB_req  in  1  engine read request
- RGB_addr  in  ADDR_W  engine read address
- RGB_data  out  PIX_W  read data (combinational)
- gray_valid  in  1  gray write strobe
- gray_addr  in  ADDR_W  gray write address
- gray_data  in  RES_W  gray write value
- lbp_valid  in  1  LBP write strobe
- lbp_addr  in  ADDR_W  LBP write address
- lbp_data  in  RES_W  LBP write value
- finish  in  1  engine completion
- rd_sel  in  1  readback select: 0 = gray buffer, 1 = LBP buffer
- rd_addr  in  ADDR_W  readback address
- rd_data  out  RES_W  readback data, registered, 1-cycle latency
- gray_cnt  out  ADDR_W+1  accepted gray writes
- lbp_cnt  out  ADDR_W+1  accepted LBP writes
- req_err  out  1  sticky: RGB_req seen while not serving
- done  out  1  finish latched

Behaviour:
- Reset (reset=0, asynchronous): state=LOAD; RGB_ready=0, rd_data=0, gray_cnt=0, lbp_cnt=0, req_err=0, done=0. Memory contents are not cleared. Reset mid-operation aborts everything and returns to LOAD.
- States:
  - LOAD: writes on load_valid. load_valid & load_last moves to SERVE on the next edge.
  - SERVE: RGB_ready=1 (registered, asserted from the first SERVE cycle).
  - DONE: entered on the edge after finish=1 is sampled in SERVE. RGB_ready=0, done=1.
  - DONE exits only on reset.
- Read path:
  - RGB_data = rgb_mem[RGB_addr] combinationally whenever RGB_req=1 in SERVE; otherwise 0.
  - The engine samples it at the edge ending the request cycle, so effective latency is 0 cycles.
  - RGB_req=1 in LOAD or DONE sets req_err; data stays 0.
- Write capture:
  - In SERVE, gray_valid writes gray_mem[gray_addr] and increments gray_cnt.
  - In SERVE, lbp_valid writes lbp_mem[lbp_addr] and increments lbp_cnt.
  - Both strobes in the same cycle are both accepted; the buffers are independent.
  - Repeated valid on one address overwrites and still counts.
  - Counters saturate at 2**ADDR_W. They never wrap.
  - Writes in LOAD or DONE are ignored and not counted.
  - finish and lbp_valid in the same cycle: the write is accepted, then DONE.
- Loading:
  - load_valid in SERVE/DONE is ignored.
  - load_last without load_valid has no effect.
- Readback: rd_data <= rd_sel ? lbp_mem[rd_addr] : gray_mem[rd_addr] on every edge in any state. Same-cycle write then read of one address returns the old value.

Optional Feature:
- Macro: LBP_IMG_HOST_CHECK_EN.
- When defined:
  - Adds output chk_err_cnt [ADDR_W:0], reset to 0.
  - Every accepted gray write is compared with (R+G+B)/3 of rgb_mem[gray_addr]. The sum is 10-bit and the quotient is truncated.
  - Each mismatch increments chk_err_cnt, saturating.
- When undefined: the port and the comparison logic are absent, and all other behaviour is identical.

Decomposition:
- Package lbp_img_pkg holds:
  - the ADDR_W/PIX_W/RES_W defaults and IMG_W=128;
  - the state enum {LOAD, SERVE, DONE};
  - function gray_of(pixel) returning the truncated (R+G+B)/3.
- One sub-module, lbp_img_ram: parameterised single-write-port RAM with one asynchronous read port and one synchronous read port.
  - One instance for rgb_mem.
  - Gray and LBP buffers are instances with the asynchronous port unused.

Test Plan:
- Load 16384 words with addr-based pattern 0x102030+addr, load_last on the final word -> RGB_ready=1 on the following cycle; RGB_req with addr 5 returns 0x102035 in the same cycle.
- RGB_req=1 before load completes -> RGB_data=0, req_err=1 and stays 1 until reset.
- Gray writes (addr 0,data 0x20) then (addr 0,data 0x21) -> gray_cnt=2; readback rd_sel=0, rd_addr=0 gives 0x21 one cycle later.
- gray_valid and lbp_valid in the same cycle (addr 7, 0x11 / addr 9, 0xAA) -> both counts increment; readbacks return 0x11 and 0xAA.
- finish together with lbp_valid (addr 16383, 0x5C) -> lbp_cnt increments, done=1 and RGB_ready=0 next cycle; a later lbp_valid is not counted.
- With LBP_IMG_HOST_CHECK_EN, pixel 0x0A0B0C at addr 3:
  - gray write 0x0B -> chk_err_cnt stays 0;
  - gray write 0x0C -> chk_err_cnt=1.
  - Assert reset mid-SERVE -> all outputs return to reset values.

Source files
------------

// File: rtl/lbp_img_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lbp_img_pkg
// Purpose  : Shared defaults, state encoding and the gray reference function
//            for the LBP image host.
// Contents : ADDR_W_DFLT / PIX_W_DFLT / RES_W_DFLT / IMG_W, state_e,
//            gray_of() (truncated (R+G+B)/3 of a packed RGB pixel).
// Revision : 1.0 - initial release
// ============================================================================
package lbp_img_pkg;

  localparam int ADDR_W_DFLT = 14;
  localparam int PIX_W_DFLT  = 24;
  localparam int RES_W_DFLT  = 8;
  localparam int IMG_W       = 128;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Three 8-bit channels sum to at most 765, so 10 bits hold the sum exactly.
  function automatic logic [RES_W_DFLT-1:0] gray_of(input logic [PIX_W_DFLT-1:0] pixel);
    logic [9:0] sum;
    sum = 10'(pixel[23:16]) + 10'(pixel[15:8]) + 10'(pixel[7:0]);
    return RES_W_DFLT'(sum / 10'd3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lbp_img_ram.sv
`default_nettype none
// ============================================================================
// Module   : lbp_img_ram
// Purpose  : Single-write-port RAM with one asynchronous read port and one
//            registered read port. Array contents are never reset; only the
//            registered read output clears on reset.
// Ports    : clk, reset (async, active-low)
//            we/waddr/wdata  - write port
//            araddr/ardata   - combinational read
//            rraddr/rdata    - registered read, 1-cycle latency, old-data
//                              on same-cycle write/read collision
// Revision : 1.0 - initial release
// ============================================================================
module lbp_img_ram
  import lbp_img_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = RES_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] araddr,
  output logic [DATA_W-1:0] ardata,
  input  logic [ADDR_W-1:0] rraddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign ardata = mem[araddr];

  always_comb begin
    rdata_d = mem[rraddr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/lbp_img_host.sv
`default_nettype none
// ============================================================================
// Module   : lbp_img_host
// Purpose  : Image-side responder for the LBP engine. Holds a preloaded RGB
//            image, serves combinational RGB reads, captures gray/LBP
//            write-backs into result buffers and latches engine completion.
// Ports    : clk, reset (async, active-low)
//            load_valid/load_addr/load_data/load_last - image loader
//            RGB_ready, RGB_req/RGB_addr/RGB_data      - engine fetch
//            gray_valid/addr/data, lbp_valid/addr/data - engine write-back
//            finish, done                              - completion
//            rd_sel/rd_addr/rd_data                    - result readback
//            gray_cnt, lbp_cnt, req_err                - status
// Option   : LBP_IMG_HOST_CHECK_EN adds chk_err_cnt, counting gray writes that
//            differ from the truncated (R+G+B)/3 of the addressed pixel.
// Revision : 1.0 - initial release
// ============================================================================
module lbp_img_host
  import lbp_img_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int PIX_W  = PIX_W_DFLT,
  parameter int RES_W  = RES_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [PIX_W-1:0]  load_data,
  input  logic              load_last,
  output logic              RGB_ready,
  input  logic              RGB_req,
  input  logic [ADDR_W-1:0] RGB_addr,
  output logic [PIX_W-1:0]  RGB_data,
  input  logic              gray_valid,
  input  logic [ADDR_W-1:0] gray_addr,
  input  logic [RES_W-1:0]  gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [RES_W-1:0]  lbp_data,
  input  logic              finish,
  input  logic              rd_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [RES_W-1:0]  rd_data,
  output logic [ADDR_W:0]   gray_cnt,
  output logic [ADDR_W:0]   lbp_cnt,
  output logic              req_err,
  output logic              done
`ifdef LBP_IMG_HOST_CHECK_EN
  ,
  output logic [ADDR_W:0]   chk_err_cnt
`endif
);

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e state_q, state_d;
  logic   ready_q, ready_d;
  logic   done_q, done_d;
  logic   req_err_q, req_err_d;
  logic   rd_sel_q, rd_sel_d;
  logic [ADDR_W:0] gray_cnt_q, gray_cnt_d;
  logic [ADDR_W:0] lbp_cnt_q, lbp_cnt_d;

  logic serving, load_we, gray_we, lbp_we;
  logic [PIX_W-1:0] rgb_async_rd, rgb_sync_rd;
  logic [RES_W-1:0] gray_rd, lbp_rd, gray_async_unused, lbp_async_unused;

  assign serving = (state_q == SERVE);
  assign load_we = (state_q == LOAD) && load_valid;
  assign gray_we = serving && gray_valid;
  assign lbp_we  = serving && lbp_valid;

  // The RGB registered port looks up the gray write address so the optional
  // checker can compare one cycle later without a second combinational port.
  lbp_img_ram #(.ADDR_W(ADDR_W), .DATA_W(PIX_W)) u_rgb_mem (
    .clk(clk), .reset(reset),
    .we(load_we), .waddr(load_addr), .wdata(load_data),
    .araddr(RGB_addr), .ardata(rgb_async_rd),
    .rraddr(gray_addr), .rdata(rgb_sync_rd)
  );

  lbp_img_ram #(.ADDR_W(ADDR_W), .DATA_W(RES_W)) u_gray_mem (
    .clk(clk), .reset(reset),
    .we(gray_we), .waddr(gray_addr), .wdata(gray_data),
    .araddr(rd_addr), .ardata(gray_async_unused),
    .rraddr(rd_addr), .rdata(gray_rd)
  );

  lbp_img_ram #(.ADDR_W(ADDR_W), .DATA_W(RES_W)) u_lbp_mem (
    .clk(clk), .reset(reset),
    .we(lbp_we), .waddr(lbp_addr), .wdata(lbp_data),
    .araddr(rd_addr), .ardata(lbp_async_unused),
    .rraddr(rd_addr), .rdata(lbp_rd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_valid && load_last) state_d = SERVE;
      SERVE:   if (finish) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    ready_d    = (state_d == SERVE);
    done_d     = (state_d == DONE);
    req_err_d  = req_err_q || (RGB_req && !serving);
    rd_sel_d   = rd_sel;
    gray_cnt_d = gray_cnt_q;
    lbp_cnt_d  = lbp_cnt_q;
    if (gray_we && (gray_cnt_q != CNT_MAX)) gray_cnt_d = gray_cnt_q + 1'b1;
    if (lbp_we && (lbp_cnt_q != CNT_MAX))   lbp_cnt_d  = lbp_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      req_err_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      gray_cnt_q <= '0;
      lbp_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      req_err_q  <= req_err_d;
      rd_sel_q   <= rd_sel_d;
      gray_cnt_q <= gray_cnt_d;
      lbp_cnt_q  <= lbp_cnt_d;
    end
  end

  assign RGB_ready = ready_q;
  assign RGB_data  = (serving && RGB_req) ? rgb_async_rd : '0;
  // Both buffer outputs are registered; the select is registered alongside
  // so rd_data reflects rd_sel/rd_addr sampled on the same edge.
  assign rd_data   = rd_sel_q ? lbp_rd : gray_rd;
  assign gray_cnt  = gray_cnt_q;
  assign lbp_cnt   = lbp_cnt_q;
  assign req_err   = req_err_q;
  assign done      = done_q;

`ifdef LBP_IMG_HOST_CHECK_EN
  logic             chk_vld_q, chk_vld_d;
  logic [RES_W-1:0] chk_data_q, chk_data_d;
  logic [ADDR_W:0]  chk_err_cnt_q, chk_err_cnt_d;

  always_comb begin
    chk_vld_d     = gray_we;
    chk_data_d    = gray_data;
    chk_err_cnt_d = chk_err_cnt_q;
    if (chk_vld_q && (RES_W'(gray_of(rgb_sync_rd)) != chk_data_q) &&
        (chk_err_cnt_q != CNT_MAX))
      chk_err_cnt_d = chk_err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_vld_q     <= 1'b0;
      chk_data_q    <= '0;
      chk_err_cnt_q <= '0;
    end else begin
      chk_vld_q     <= chk_vld_d;
      chk_data_q    <= chk_data_d;
      chk_err_cnt_q <= chk_err_cnt_d;
    end
  end

  assign chk_err_cnt = chk_err_cnt_q;
`else
  logic rgb_sync_unused;
  assign rgb_sync_unused = ^rgb_sync_rd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lbp_img_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbp_img_host
// Purpose  : Self-checking bench for lbp_img_host. Readback expectations are
//            queued when the read is driven and compared when rd_data appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbp_img_host;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid, load_last;
  logic [AW-1:0] load_addr;
  logic [23:0]   load_data;
  logic          RGB_ready, RGB_req;
  logic [AW-1:0] RGB_addr;
  logic [23:0]   RGB_data;
  logic          gray_valid, lbp_valid, finish, rd_sel;
  logic [AW-1:0] gray_addr, lbp_addr, rd_addr;
  logic [7:0]    gray_data, lbp_data, rd_data;
  logic [AW:0]   gray_cnt, lbp_cnt;
  logic          req_err, done;
`ifdef LBP_IMG_HOST_CHECK_EN
  logic [AW:0]   chk_err_cnt;
`endif

  lbp_img_host dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
    .RGB_ready(RGB_ready), .RGB_req(RGB_req), .RGB_addr(RGB_addr), .RGB_data(RGB_data),
    .gray_valid(gray_valid), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .gray_cnt(gray_cnt), .lbp_cnt(lbp_cnt), .req_err(req_err), .done(done)
`ifdef LBP_IMG_HOST_CHECK_EN
    , .chk_err_cnt(chk_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] gray_m [int];
  logic [7:0] lbp_m [int];
  int exp_gray_cnt = 0, exp_lbp_cnt = 0, exp_chk = 0, exp_st = 0;
  logic [7:0] rb_q [$];
  logic [7:0] rb_exp;

  function automatic logic [23:0] pix(int i);
    return (i == 3) ? 24'h0A0B0C : 24'h102030 + 24'(i);
  endfunction

  function automatic logic [7:0] ref_gray(logic [23:0] p);
    int s;
    s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    return 8'(s / 3);
  endfunction

  // Advance the reference model with the inputs currently driven, then clock.
  task automatic clk_cycle();
    if (exp_st == 1) begin
      if (gray_valid) begin
        gray_m[int'(gray_addr)] = gray_data;
        if (exp_gray_cnt < DEPTH) exp_gray_cnt++;
        if (ref_gray(pix(int'(gray_addr))) != gray_data && exp_chk < DEPTH) exp_chk++;
      end
      if (lbp_valid) begin
        lbp_m[int'(lbp_addr)] = lbp_data;
        if (exp_lbp_cnt < DEPTH) exp_lbp_cnt++;
      end
      if (finish) exp_st = 2;
    end else if (exp_st == 0 && load_valid && load_last) begin
      exp_st = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic push_rb();
    rb_q.push_back(rd_sel ? lbp_m[int'(rd_addr)] : gray_m[int'(rd_addr)]);
  endtask

  task automatic model_reset();
    exp_gray_cnt = 0; exp_lbp_cnt = 0; exp_chk = 0; exp_st = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    clk_cycle(); clk_cycle();
    n_total++; if (RGB_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", RGB_ready); else n_pass++;
    n_total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", rd_data); else n_pass++;
    n_total++; if (gray_cnt !== '0) $display("FAIL reset_gray_cnt: got %0d expected 0", gray_cnt); else n_pass++;
    n_total++; if (lbp_cnt !== '0) $display("FAIL reset_lbp_cnt: got %0d expected 0", lbp_cnt); else n_pass++;
    n_total++; if (req_err !== 1'b0) $display("FAIL reset_req_err: got %b expected 0", req_err); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
`ifdef LBP_IMG_HOST_CHECK_EN
    n_total++; if (chk_err_cnt !== '0) $display("FAIL reset_chk: got %0d expected 0", chk_err_cnt); else n_pass++;
`endif
    reset = 1'b1;
    clk_cycle();
  endtask

  task automatic test_req_before_load();
    RGB_req = 1'b1; RGB_addr = 14'd5;
    #1;
    n_total++; if (RGB_data !== 24'h0) $display("FAIL early_rgb_data: got %h expected 000000", RGB_data); else n_pass++;
    clk_cycle();
    RGB_req = 1'b0;
    n_total++; if (req_err !== 1'b1) $display("FAIL early_req_err: got %b expected 1", req_err); else n_pass++;
  endtask

  task automatic test_load();
    int addrs[4] = '{0, 3, 1000, 16383};
    load_last = 1'b1; load_valid = 1'b0;
    clk_cycle();
    load_last = 1'b0;
    n_total++; if (RGB_ready !== 1'b0) $display("FAIL last_alone_ready: got %b expected 0", RGB_ready); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1; load_addr = AW'(i); load_data = pix(i); load_last = (i == DEPTH - 1);
      if (i == DEPTH - 1) begin
        n_total++; if (RGB_ready !== 1'b0) $display("FAIL ready_before_last: got %b expected 0", RGB_ready); else n_pass++;
      end
      clk_cycle();
    end
    load_valid = 1'b0; load_last = 1'b0;
    n_total++; if (RGB_ready !== 1'b1) $display("FAIL ready_after_load: got %b expected 1", RGB_ready); else n_pass++;
    RGB_req = 1'b1; RGB_addr = 14'd5;
    #1;
    n_total++; if (RGB_data !== 24'h102035) $display("FAIL rgb_addr5: got %h expected 102035", RGB_data); else n_pass++;
    foreach (addrs[k]) begin
      RGB_addr = AW'(addrs[k]);
      #1;
      n_total++; if (RGB_data !== pix(addrs[k])) $display("FAIL rgb_read[%0d]: got %h expected %h", addrs[k], RGB_data, pix(addrs[k])); else n_pass++;
    end
    RGB_req = 1'b0;
    #1;
    n_total++; if (RGB_data !== 24'h0) $display("FAIL rgb_no_req: got %h expected 000000", RGB_data); else n_pass++;
    // A load strobe while serving must not disturb the image.
    load_valid = 1'b1; load_addr = 14'd5; load_data = 24'h0;
    clk_cycle();
    load_valid = 1'b0;
    RGB_req = 1'b1; RGB_addr = 14'd5;
    #1;
    n_total++; if (RGB_data !== 24'h102035) $display("FAIL load_in_serve: got %h expected 102035", RGB_data); else n_pass++;
    RGB_req = 1'b0;
    n_total++; if (req_err !== 1'b1) $display("FAIL req_err_sticky: got %b expected 1", req_err); else n_pass++;
  endtask

  task automatic test_gray_overwrite();
    gray_valid = 1'b1; gray_addr = 14'd0; gray_data = 8'h20;
    clk_cycle();
    gray_data = 8'h21;
    clk_cycle();
    gray_valid = 1'b0;
    n_total++; if (gray_cnt !== (AW+1)'(exp_gray_cnt)) $display("FAIL gray_cnt_overwrite: got %0d expected %0d", gray_cnt, exp_gray_cnt); else n_pass++;
    rd_sel = 1'b0; rd_addr = 14'd0; push_rb();
    clk_cycle();
    rb_exp = rb_q.pop_front();
    n_total++; if (rd_data !== rb_exp) $display("FAIL rb_gray0: got %h expected %h", rd_data, rb_exp); else n_pass++;
    gray_valid = 1'b1; gray_addr = 14'd1; gray_data = 8'h44;
    clk_cycle();
    gray_data = 8'h55; rd_addr = 14'd1; push_rb();
    clk_cycle();
    gray_valid = 1'b0;
    rb_exp = rb_q.pop_front();
    n_total++; if (rd_data !== rb_exp) $display("FAIL rb_collision_old: got %h expected %h", rd_data, rb_exp); else n_pass++;
    push_rb();
    clk_cycle();
    rb_exp = rb_q.pop_front();
    n_total++; if (rd_data !== rb_exp) $display("FAIL rb_collision_new: got %h expected %h", rd_data, rb_exp); else n_pass++;
  endtask

  task automatic test_dual_write();
    gray_valid = 1'b1; gray_addr = 14'd7; gray_data = 8'h11;
    lbp_valid = 1'b1; lbp_addr = 14'd9; lbp_data = 8'hAA;
    clk_cycle();
    gray_valid = 1'b0; lbp_valid = 1'b0;
    n_total++; if (gray_cnt !== (AW+1)'(exp_gray_cnt)) $display("FAIL dual_gray_cnt: got %0d expected %0d", gray_cnt, exp_gray_cnt); else n_pass++;
    n_total++; if (lbp_cnt !== (AW+1)'(exp_lbp_cnt)) $display("FAIL dual_lbp_cnt: got %0d expected %0d", lbp_cnt, exp_lbp_cnt); else n_pass++;
    rd_sel = 1'b0; rd_addr = 14'd7; push_rb();
    clk_cycle();
    rd_sel = 1'b1; rd_addr = 14'd9; push_rb();
    rb_exp = rb_q.pop_front();
    n_total++; if (rd_data !== rb_exp) $display("FAIL rb_gray7: got %h expected %h", rd_data, rb_exp); else n_pass++;
    clk_cycle();
    rb_exp = rb_q.pop_front();
    n_total++; if (rd_data !== rb_exp) $display("FAIL rb_lbp9: got %h expected %h", rd_data, rb_exp); else n_pass++;
  endtask

  task automatic test_check();
`ifdef LBP_IMG_HOST_CHECK_EN
    int base;
    base = exp_chk;
    gray_valid = 1'b1; gray_addr = 14'd3; gray_data = 8'h0B;
    clk_cycle();
    gray_valid = 1'b0;
    clk_cycle();
    n_total++; if (chk_err_cnt !== (AW+1)'(base)) $display("FAIL chk_match: got %0d expected %0d", chk_err_cnt, base); else n_pass++;
    gray_valid = 1'b1; gray_data = 8'h0C;
    clk_cycle();
    gray_valid = 1'b0;
    clk_cycle();
    n_total++; if (chk_err_cnt !== (AW+1)'(base + 1)) $display("FAIL chk_mismatch: got %0d expected %0d", chk_err_cnt, base + 1); else n_pass++;
`endif
  endtask

  task automatic test_finish();
    lbp_valid = 1'b1; lbp_addr = 14'd16383; lbp_data = 8'h5C; finish = 1'b1;
    clk_cycle();
    lbp_valid = 1'b0; finish = 1'b0;
    n_total++; if (lbp_cnt !== (AW+1)'(exp_lbp_cnt)) $display("FAIL finish_lbp_cnt: got %0d expected %0d", lbp_cnt, exp_lbp_cnt); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL finish_done: got %b expected 1", done); else n_pass++;
    n_total++; if (RGB_ready !== 1'b0) $display("FAIL finish_ready: got %b expected 0", RGB_ready); else n_pass++;
    lbp_valid = 1'b1; lbp_addr = 14'd20; lbp_data = 8'h77;
    gray_valid = 1'b1; gray_addr = 14'd21; gray_data = 8'h66;
    clk_cycle();
    lbp_valid = 1'b0; gray_valid = 1'b0;
    n_total++; if (lbp_cnt !== (AW+1)'(exp_lbp_cnt)) $display("FAIL done_lbp_ignored: got %0d expected %0d", lbp_cnt, exp_lbp_cnt); else n_pass++;
    n_total++; if (gray_cnt !== (AW+1)'(exp_gray_cnt)) $display("FAIL done_gray_ignored: got %0d expected %0d", gray_cnt, exp_gray_cnt); else n_pass++;
    rd_sel = 1'b1; rd_addr = 14'd16383; push_rb();
    clk_cycle();
    rb_exp = rb_q.pop_front();
    n_total++; if (rd_data !== rb_exp) $display("FAIL rb_lbp_last: got %h expected %h", rd_data, rb_exp); else n_pass++;
    RGB_req = 1'b1; RGB_addr = 14'd5;
    #1;
    n_total++; if (RGB_data !== 24'h0) $display("FAIL done_rgb_data: got %h expected 000000", RGB_data); else n_pass++;
    RGB_req = 1'b0;
    n_total++; if (done !== 1'b1) $display("FAIL done_held: got %b expected 1", done); else n_pass++;
  endtask

  task automatic test_saturation();
    reset = 1'b0; model_reset();
    clk_cycle();
    reset = 1'b1;
    RGB_req = 1'b1; RGB_addr = 14'd0;
    clk_cycle();
    RGB_req = 1'b0;
    load_valid = 1'b1; load_addr = 14'd0; load_data = pix(0); load_last = 1'b1;
    clk_cycle();
    load_valid = 1'b0; load_last = 1'b0;
    n_total++; if (RGB_ready !== 1'b1) $display("FAIL reload_ready: got %b expected 1", RGB_ready); else n_pass++;
    for (int i = 0; i < DEPTH + 2; i++) begin
      gray_valid = 1'b1; gray_addr = AW'(i % DEPTH); gray_data = 8'(i);
      clk_cycle();
    end
    gray_valid = 1'b0;
    rd_sel = 1'b0; rd_addr = 14'd100; push_rb();
    clk_cycle();
    rb_exp = rb_q.pop_front();
    n_total++; if (gray_cnt !== (AW+1)'(DEPTH)) $display("FAIL gray_cnt_sat: got %0d expected %0d", gray_cnt, DEPTH); else n_pass++;
    n_total++; if (rd_data !== rb_exp) $display("FAIL rb_after_sat: got %h expected %h", rd_data, rb_exp); else n_pass++;
`ifdef LBP_IMG_HOST_CHECK_EN
    n_total++; if (chk_err_cnt !== (AW+1)'(exp_chk)) $display("FAIL chk_after_sat: got %0d expected %0d", chk_err_cnt, exp_chk); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_serve();
    lbp_valid = 1'b1; lbp_addr = 14'd2; lbp_data = 8'h3C; rd_sel = 1'b1; rd_addr = 14'd16383;
    clk_cycle();
    lbp_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_total++; if (RGB_ready !== 1'b0) $display("FAIL mid_reset_ready: got %b expected 0", RGB_ready); else n_pass++;
    n_total++; if (rd_data !== 8'h00) $display("FAIL mid_reset_rd_data: got %h expected 00", rd_data); else n_pass++;
    n_total++; if (gray_cnt !== '0) $display("FAIL mid_reset_gray_cnt: got %0d expected 0", gray_cnt); else n_pass++;
    n_total++; if (lbp_cnt !== '0) $display("FAIL mid_reset_lbp_cnt: got %0d expected 0", lbp_cnt); else n_pass++;
    n_total++; if (req_err !== 1'b0) $display("FAIL mid_reset_req_err: got %b expected 0", req_err); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL mid_reset_done: got %b expected 0", done); else n_pass++;
`ifdef LBP_IMG_HOST_CHECK_EN
    n_total++; if (chk_err_cnt !== '0) $display("FAIL mid_reset_chk: got %0d expected 0", chk_err_cnt); else n_pass++;
`endif
    model_reset();
    clk_cycle();
    reset = 1'b1;
    gray_valid = 1'b1; gray_addr = 14'd4; gray_data = 8'h01;
    clk_cycle();
    gray_valid = 1'b0;
    n_total++; if (gray_cnt !== (AW+1)'(exp_gray_cnt)) $display("FAIL load_gray_ignored: got %0d expected %0d", gray_cnt, exp_gray_cnt); else n_pass++;
    n_total++; if (RGB_ready !== 1'b0) $display("FAIL back_in_load_ready: got %b expected 0", RGB_ready); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
    RGB_req = 1'b0; RGB_addr = '0;
    gray_valid = 1'b0; gray_addr = '0; gray_data = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0;
    finish = 1'b0; rd_sel = 1'b0; rd_addr = '0;
    test_reset();
    test_req_before_load();
    test_load();
    test_gray_overwrite();
    test_dual_write();
    test_check();
    test_finish();
    test_saturation();
    test_reset_mid_serve();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
